// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU/multiplier.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic MODE_ALU = 1'b0;
   localparam logic MODE_MUL = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational operand presets followed by add/and and optional output inversion.
module alu_core #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH-1:0] xa, xb, ya, yb, raw;
   logic [WIDTH:0]   sum;

   // Zero then invert each operand, select function, then optionally invert.
   always_comb begin
      xa     = zx ? '0 : x;
      xb     = nx ? ~xa : xa;
      ya     = zy ? '0 : y;
      yb     = ny ? ~ya : ya;
      sum    = (WIDTH+1)'(xb) + (WIDTH+1)'(yb);
      raw    = f ? sum[WIDTH-1:0] : (xb & yb);
      result = no ? ~raw : raw;
      carry  = f & sum[WIDTH];
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/and path and a WIDTH-cycle shift-add multiplier,
// with a valid/ready handshake on both the operand and result sides.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             cy
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   state_t           state;
   logic [PW-1:0]    mcand, acc, acc_next;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic             mul_no;
   logic [WIDTH-1:0] alu_res, px, py, fin_res;
   logic             alu_cy;
   logic             unused_cy_px, unused_cy_py, unused_cy_fin;
   logic             xfer, last_step;

   // Full ALU function for the single-cycle path.
   alu_core #(.WIDTH(WIDTH)) u_alu (
      .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
      .result(alu_res), .carry(alu_cy)
   );

   // Preset x for the multiplier: AND with an all-ones second operand passes it through.
   alu_core #(.WIDTH(WIDTH)) u_px (
      .x(x), .y('0), .zx(zx), .nx(nx), .zy(1'b1), .ny(1'b1), .f(1'b0), .no(1'b0),
      .result(px), .carry(unused_cy_px)
   );

   // Preset y for the multiplier, same pass-through trick.
   alu_core #(.WIDTH(WIDTH)) u_py (
      .x(y), .y('0), .zx(zy), .nx(ny), .zy(1'b1), .ny(1'b1), .f(1'b0), .no(1'b0),
      .result(py), .carry(unused_cy_py)
   );

   // Optional inversion of the finished low product word.
   alu_core #(.WIDTH(WIDTH)) u_fin (
      .x(acc_next[WIDTH-1:0]), .y('0), .zx(1'b0), .nx(1'b0), .zy(1'b1), .ny(1'b1),
      .f(1'b0), .no(mul_no), .result(fin_res), .carry(unused_cy_fin)
   );

   assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
   assign xfer      = in_valid & in_ready;
   assign acc_next  = mplier[0] ? (acc + mcand) : acc;
   assign last_step = (cnt == CW'(WIDTH - 1));

   // Control FSM, multiplier datapath and registered result/flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out       <= '0;
         zr        <= 1'b0;
         ng        <= 1'b0;
         cy        <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         mul_no    <= 1'b0;
      end else if (xfer) begin
         if (mode == MODE_ALU) begin
            out       <= alu_res;
            zr        <= (alu_res == '0);
            ng        <= alu_res[WIDTH-1];
            cy        <= alu_cy;
            state     <= HOLD;
            out_valid <= 1'b1;
         end else begin
            mcand     <= PW'(px);
            mplier    <= py;
            acc       <= '0;
            cnt       <= '0;
            mul_no    <= no;
            state     <= MUL;
            out_valid <= 1'b0;
         end
      end else begin
         case (state)
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last_step) begin
                  out       <= fin_res;
                  zr        <= (fin_res == '0);
                  ng        <= fin_res[WIDTH-1];
                  cy        <= |acc_next[PW-1:WIDTH];
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16) with an expected-result queue.
module tb_alu_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
   logic         mode = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out;
   logic         zr, ng, cy;
   logic [W+2:0] obs;

   int checks = 0;
   int failures = 0;
   logic [W+2:0] sb[$];

   assign obs = {out, zr, ng, cy};

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
      .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .zr(zr), .ng(ng), .cy(cy)
   );

   always #5 clk = ~clk;

   // Reference model: returns {out, zr, ng, cy}; ctl is {zx,nx,zy,ny,f,no}.
   function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [5:0] c, input logic m);
      logic [W-1:0]   pa, pb, r;
      logic [2*W-1:0] p;
      logic [W:0]     s;
      logic           c_o;
      pa = c[5] ? '0 : a;
      if (c[4]) pa = ~pa;
      pb = c[3] ? '0 : b;
      if (c[2]) pb = ~pb;
      if (m) begin
         p   = (2*W)'(pa) * (2*W)'(pb);
         r   = p[W-1:0];
         c_o = |p[2*W-1:W];
      end else if (c[1]) begin
         s   = (W+1)'(pa) + (W+1)'(pb);
         r   = s[W-1:0];
         c_o = s[W];
      end else begin
         r   = pa & pb;
         c_o = 1'b0;
      end
      if (c[0]) r = ~r;
      return {r, (r == '0), r[W-1], c_o};
   endfunction

   function automatic logic [W+2:0] pop_exp();
      if (sb.size() == 0) return 'x;
      return sb.pop_front();
   endfunction

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [5:0] c, input logic m);
      x = a;
      y = b;
      {zx, nx, zy, ny, f, no} = c;
      mode = m;
      in_valid = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, obs} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", {out_valid, obs});
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_add();
      logic [W+2:0] e;
      @(negedge clk);
      drive(16'd5, 16'd3, 6'b000010, 1'b0);
      sb.push_back({16'd8, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL add_latency out_valid=%b want=1", out_valid);
      end
      e = pop_exp();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL add_result got=%h want=%h", obs, e);
      end
      @(negedge clk);
   endtask

   task automatic test_sub();
      logic [W+2:0] e;
      @(negedge clk);
      drive(16'd3, 16'd5, 6'b010011, 1'b0);
      sb.push_back({16'hFFFE, 1'b0, 1'b1, 1'b1});
      @(negedge clk);
      in_valid = 1'b0;
      e = pop_exp();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
         failures++;
         $display("FAIL sub_neg valid=%b got=%h want=%h", out_valid, obs, e);
      end
      @(negedge clk);
      drive(16'd7, 16'd7, 6'b010011, 1'b0);
      sb.push_back({16'h0000, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      e = pop_exp();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
         failures++;
         $display("FAIL sub_zero valid=%b got=%h want=%h", out_valid, obs, e);
      end
      @(negedge clk);
   endtask

   task automatic test_mul();
      logic [W+2:0] e;
      int lat, bad;
      @(negedge clk);
      drive(16'd300, 16'd300, 6'b000000, 1'b1);
      sb.push_back({16'h5F90, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      // Keep presenting a different bundle during MUL; it must be ignored.
      drive(16'hAAAA, 16'h5555, 6'b000010, 1'b0);
      lat = 1;
      bad = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready !== 1'b0) bad++;
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      checks++;
      if (lat != 17) begin
         failures++;
         $display("FAIL mul_latency got=%0d want=17", lat);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mul_in_ready high_cycles=%0d want=0", bad);
      end
      e = pop_exp();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL mul_result got=%h want=%h", obs, e);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mul_ignored_bundle out_valid=%b want=0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [W+2:0] e0, e;
      logic [W-1:0] a, b;
      logic [5:0]   c;
      @(negedge clk);
      out_ready = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      drive(a, b, 6'b000010, 1'b0);
      sb.push_back(model(a, b, 6'b000010, 1'b0));
      @(negedge clk);
      in_valid = 1'b0;
      e0 = pop_exp();
      checks++;
      if (out_valid !== 1'b1 || obs !== e0) begin
         failures++;
         $display("FAIL bp_first valid=%b got=%h want=%h", out_valid, obs, e0);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || obs !== e0) begin
            failures++;
            $display("FAIL bp_hold_%0d valid=%b got=%h want=%h", k, out_valid, obs, e0);
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         c = {4'($urandom), 1'b1, 1'($urandom)};
         drive(a, b, c, 1'b0);
         sb.push_back(model(a, b, c, 1'b0));
         @(negedge clk);
         e = pop_exp();
         checks++;
         if (out_valid !== 1'b1 || obs !== e) begin
            failures++;
            $display("FAIL stream_%0d valid=%b got=%h want=%h", i, out_valid, obs, e);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_drain out_valid=%b want=0", out_valid);
      end
   endtask

   task automatic test_random();
      logic [W+2:0] e;
      logic [W-1:0] a, b;
      logic [5:0]   c;
      logic         m;
      int           lat;
      for (int i = 0; i < 10; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         c = 6'($urandom);
         m = ($urandom_range(0, 2) == 0);
         if (i == 0) begin
            c = 6'b000001;
            m = 1'b1;
         end
         @(negedge clk);
         drive(a, b, c, m);
         sb.push_back(model(a, b, c, m));
         @(negedge clk);
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         checks++;
         if (lat != (m ? 17 : 1)) begin
            failures++;
            $display("FAIL rand_latency_%0d got=%0d want=%0d", i, lat, (m ? 17 : 1));
         end
         e = pop_exp();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL rand_result_%0d mode=%b ctl=%b got=%h want=%h", i, m, c, obs, e);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_mul();
      logic [W+2:0] e;
      int lat;
      @(negedge clk);
      drive(16'd300, 16'd300, 6'b000000, 1'b1);
      sb.push_back({16'h5F90, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #1;
      sb.delete();
      checks++;
      if ({out_valid, obs} !== '0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midmul_reset outs=%h in_ready=%b want=0/1", {out_valid, obs}, in_ready);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, obs} !== '0) begin
         failures++;
         $display("FAIL midmul_reset_held outs=%h want=0", {out_valid, obs});
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midmul_release_in_ready got=%b want=1", in_ready);
      end
      drive(16'd2, 16'd3, 6'b000000, 1'b1);
      sb.push_back({16'd6, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 17) begin
         failures++;
         $display("FAIL midmul_new_latency got=%0d want=17", lat);
      end
      e = pop_exp();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL midmul_new_result got=%h want=%h", obs, e);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_backpressure();
      test_random();
      test_reset_mid_mul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
